// File: rtl/rd_cpu_reg.sv
// Debug register read-out: a UART command selects CPU registers, which are read over
// the debug port and returned as an echo, data, checksum frame (or a NACK byte).
module rd_cpu_reg (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [7:0] opcode,
   output logic       dbg_rd,
   output logic [2:0] dbg_addr,
   input  logic [7:0] dbg_data,
   input  logic       dbg_valid,
   input  logic       ctl_busy,
   input  logic       tx_busy,
   output logic       tx_en,
   output logic [7:0] tx_data,
   output logic       busy
);

   typedef enum logic [2:0] {
      S_Idle, S_WaitCpu, S_Read, S_ReadWait, S_Send, S_Gap
   } state_t;

   // Which part of the frame the byte just sent belongs to.
   typedef enum logic [1:0] {PH_ECHO, PH_DATA, PH_LAST} phase_t;

   state_t     state_q = S_Idle, state_d;
   phase_t     phase_q = PH_ECHO, phase_d;
   logic [2:0] idx_q = 3'd0, idx_d;
   logic [2:0] last_q = 3'd0, last_d;
   logic [7:0] pend_q = 8'h00, pend_d;
   logic [7:0] csum_q = 8'h00, csum_d;
   logic [4:0] tmo_q = 5'd0, tmo_d;
   logic       tx_en_q = 1'b0, tx_en_d;
   logic [7:0] tx_data_q = 8'h00, tx_data_d;
   logic       dbg_rd_q = 1'b0, dbg_rd_d;
   logic [2:0] dbg_addr_q = 3'd0, dbg_addr_d;

   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      idx_d      = idx_q;
      last_d     = last_q;
      pend_d     = pend_q;
      csum_d     = csum_q;
      tmo_d      = tmo_q;
      tx_en_d    = 1'b0;
      tx_data_d  = tx_data_q;
      dbg_rd_d   = 1'b0;
      dbg_addr_d = dbg_addr_q;
      case (state_q)
         S_Idle: begin
            if (en && opcode[7:4] == 4'h1) begin
               csum_d  = opcode;
               tmo_d   = 5'd0;
               state_d = S_Send;
               if (opcode[3:0] > 4'd6) begin
                  pend_d  = {4'hE, opcode[3:0]};
                  phase_d = PH_LAST;
               end else begin
                  pend_d  = opcode;
                  phase_d = PH_ECHO;
                  case (opcode[2:0])
                     3'd5:    begin idx_d = 3'd5; last_d = 3'd6; end
                     3'd6:    begin idx_d = 3'd0; last_d = 3'd6; end
                     default: begin idx_d = opcode[2:0]; last_d = opcode[2:0]; end
                  endcase
               end
            end
         end
         // dbg_rd/dbg_addr are registered here so the pulse lines up with S_Read.
         S_WaitCpu: begin
            if (!ctl_busy) begin
               dbg_rd_d   = 1'b1;
               dbg_addr_d = idx_q;
               state_d    = S_Read;
            end
         end
         S_Read: begin
            tmo_d   = 5'd0;
            state_d = S_ReadWait;
         end
         S_ReadWait: begin
            if (dbg_valid) begin
               pend_d  = dbg_data;
               csum_d  = csum_q ^ dbg_data;
               state_d = S_Send;
            end else if (tmo_q == 5'd15) begin
               pend_d  = 8'hFF;
               csum_d  = csum_q ^ 8'hFF;
               state_d = S_Send;
            end else begin
               tmo_d = tmo_q + 5'd1;
            end
         end
         S_Send: begin
            if (!tx_busy) begin
               tx_en_d   = 1'b1;
               tx_data_d = pend_q;
               state_d   = S_Gap;
            end
         end
         S_Gap: begin
            case (phase_q)
               PH_ECHO: begin
                  phase_d = PH_DATA;
                  state_d = S_WaitCpu;
               end
               PH_DATA: begin
                  if (idx_q != last_q) begin
                     idx_d   = idx_q + 3'd1;
                     state_d = S_WaitCpu;
                  end else begin
                     pend_d  = csum_q;
                     phase_d = PH_LAST;
                     state_d = S_Send;
                  end
               end
               default: state_d = S_Idle;
            endcase
         end
         default: state_d = S_Idle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_Idle;
         phase_q    <= PH_ECHO;
         idx_q      <= 3'd0;
         last_q     <= 3'd0;
         pend_q     <= 8'h00;
         csum_q     <= 8'h00;
         tmo_q      <= 5'd0;
         tx_en_q    <= 1'b0;
         tx_data_q  <= 8'h00;
         dbg_rd_q   <= 1'b0;
         dbg_addr_q <= 3'd0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         idx_q      <= idx_d;
         last_q     <= last_d;
         pend_q     <= pend_d;
         csum_q     <= csum_d;
         tmo_q      <= tmo_d;
         tx_en_q    <= tx_en_d;
         tx_data_q  <= tx_data_d;
         dbg_rd_q   <= dbg_rd_d;
         dbg_addr_q <= dbg_addr_d;
      end
   end

   assign tx_en    = tx_en_q;
   assign tx_data  = tx_data_q;
   assign dbg_rd   = dbg_rd_q;
   assign dbg_addr = dbg_addr_q;
   assign busy     = (state_q != S_Idle);

endmodule

// File: tb/tb_rd_cpu_reg.sv
// Randomized bench for rd_cpu_reg: CPU and UART models around the DUT, expected
// frames built from the command rules and compared against captured tx/dbg traffic.
module tb_rd_cpu_reg;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [7:0] opcode;
   logic       dbg_rd;
   logic [2:0] dbg_addr;
   logic [7:0] dbg_data;
   logic       dbg_valid;
   logic       ctl_busy;
   logic       tx_busy;
   logic       tx_en;
   logic [7:0] tx_data;
   logic       busy;

   logic [7:0] regs [7];
   logic       withhold = 1'b0;
   logic       cpu_valid = 1'b0;
   logic [7:0] cpu_data = 8'h00;
   logic       stray_v = 1'b0;
   logic [7:0] stray_d = 8'h00;
   logic       ctl_stall = 1'b0, ctl_jit = 1'b0;
   logic       tx_stall = 1'b0, tx_busy_m = 1'b0;
   logic [7:0] txq [$];
   logic [2:0] rdq [$];
   int         n_chk = 0;
   int         n_fail = 0;
   int         cyc_cnt = 0;
   int         last_tx = -100;

   assign dbg_valid = cpu_valid | stray_v;
   assign dbg_data  = stray_v ? stray_d : cpu_data;
   assign ctl_busy  = ctl_stall | ctl_jit;
   assign tx_busy   = tx_stall | tx_busy_m;

   rd_cpu_reg dut (
      .clk(clk), .rst(rst), .en(en), .opcode(opcode),
      .dbg_rd(dbg_rd), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_valid(dbg_valid),
      .ctl_busy(ctl_busy), .tx_busy(tx_busy), .tx_en(tx_en), .tx_data(tx_data), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // CPU model: answers each dbg_rd 1..6 cycles later unless withheld.
   initial begin
      logic [2:0] a;
      forever begin
         @(negedge clk);
         cpu_valid = 1'b0;
         if (dbg_rd && !rst && !withhold) begin
            a = dbg_addr;
            repeat ($urandom_range(1, 6)) @(negedge clk);
            cpu_data  = regs[a];
            cpu_valid = 1'b1;
         end
      end
   end

   // UART model: busy for 1..4 cycles after each send.
   initial begin
      int cnt = 0;
      forever begin
         @(negedge clk);
         if (tx_en && !rst) cnt = $urandom_range(1, 4);
         else if (cnt > 0) cnt--;
         tx_busy_m = (cnt > 0);
         ctl_jit   = ($urandom_range(0, 3) == 0);
      end
   end

   // Monitor: records traffic and checks the pulse rules.
   initial begin
      forever begin
         @(negedge clk);
         cyc_cnt++;
         if (!rst) begin
            if (tx_en) begin
               txq.push_back(tx_data);
               chk("tx_spacing_ok", 32'(cyc_cnt - last_tx >= 2), 1);
               chk("tx_en_and_dbg_rd", 32'(dbg_rd), 0);
               last_tx = cyc_cnt;
            end
            if (dbg_rd) rdq.push_back(dbg_addr);
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic run_cmd(input logic [7:0] op, input bit wh, input bit stall, input int exp_last);
      logic [7:0] eb [$];
      logic [2:0] ea [$];
      logic [7:0] x, d;
      int n, cyc;
      n = int'(op[3:0]);
      if (op[7:4] == 4'h1) begin
         if (n > 6) eb.push_back({4'hE, op[3:0]});
         else begin
            if (n == 6) for (int i = 0; i < 7; i++) ea.push_back(3'(i));
            else if (n == 5) begin ea.push_back(3'd5); ea.push_back(3'd6); end
            else ea.push_back(3'(n));
            eb.push_back(op);
            x = op;
            foreach (ea[k]) begin
               d = wh ? 8'hFF : regs[ea[k]];
               eb.push_back(d);
               x = x ^ d;
            end
            eb.push_back(x);
         end
      end
      withhold = wh;
      txq.delete();
      rdq.delete();
      @(negedge clk);
      en = 1'b1;
      opcode = op;
      if (stall) begin ctl_stall = 1'b1; tx_stall = 1'b1; end
      @(negedge clk);
      en = 1'b0;
      opcode = 8'($urandom);
      if (stall) begin
         repeat (29) @(negedge clk);
         chk("tx_stall_no_tx", txq.size(), 0);
         tx_stall = 1'b0;
         repeat (20) @(negedge clk);
         chk("ctl_stall_no_rd", rdq.size(), 0);
         ctl_stall = 1'b0;
      end
      if (eb.size() == 0) begin
         repeat (6) begin
            chk("ignored_busy", 32'(busy), 0);
            @(negedge clk);
         end
      end else begin
         cyc = 0;
         while (busy && cyc < 2000) begin
            @(negedge clk);
            cyc++;
         end
         chk("frame_done_in_time", 32'(cyc < 2000), 1);
      end
      chk("tx_count", txq.size(), eb.size());
      for (int i = 0; i < eb.size() && i < txq.size(); i++) chk("tx_byte", txq[i], eb[i]);
      chk("rd_count", rdq.size(), ea.size());
      for (int i = 0; i < ea.size() && i < rdq.size(); i++) chk("rd_addr", rdq[i], ea[i]);
      if (exp_last >= 0 && txq.size() > 0) chk("last_byte_lit", txq[txq.size()-1], exp_last);
      withhold = 1'b0;
   endtask

   initial begin
      int c;
      logic [7:0] op;
      rst = 1'b1;
      en = 1'b0;
      opcode = 8'h00;
      foreach (regs[i]) regs[i] = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_tx_en", 32'(tx_en), 0);
      chk("rst_dbg_rd", 32'(dbg_rd), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_dbg_addr", dbg_addr, 0);
      rst = 1'b0;

      regs[0] = 8'h3C;
      run_cmd(8'h10, 1'b0, 1'b0, 'h2C);
      regs[5] = 8'h00; regs[6] = 8'hC0;
      run_cmd(8'h15, 1'b0, 1'b0, 'hD5);
      foreach (regs[i]) regs[i] = 8'(i + 1);
      run_cmd(8'h16, 1'b0, 1'b0, 'h16);
      run_cmd(8'h1A, 1'b0, 1'b0, 'hEA);
      run_cmd(8'h02, 1'b0, 1'b0, -1);
      run_cmd(8'h16, 1'b0, 1'b1, -1);
      run_cmd(8'h11, 1'b1, 1'b0, 'hEE);

      // Reset while a read is outstanding.
      withhold = 1'b1;
      @(negedge clk);
      en = 1'b1; opcode = 8'h16;
      @(negedge clk);
      en = 1'b0;
      c = 0;
      while (!dbg_rd && c < 200) begin @(negedge clk); c++; end
      chk("midrst_saw_rd", 32'(dbg_rd), 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_tx_en", 32'(tx_en), 0);
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_dbg_rd", 32'(dbg_rd), 0);
      rst = 1'b0;
      txq.delete();
      rdq.delete();
      repeat (30) @(negedge clk);
      chk("midrst_no_tx", txq.size(), 0);
      chk("midrst_no_rd", rdq.size(), 0);
      withhold = 1'b0;
      regs[0] = 8'h3C;
      run_cmd(8'h10, 1'b0, 1'b0, 'h2C);

      for (int t = 0; t < 25; t++) begin
         foreach (regs[i]) regs[i] = 8'($urandom);
         @(negedge clk);
         stray_v = 1'b1; stray_d = 8'($urandom);
         @(negedge clk);
         stray_v = 1'b0;
         op = ($urandom_range(0, 4) == 0) ? 8'($urandom) : {4'h1, 4'($urandom)};
         run_cmd(op, ($urandom_range(0, 7) == 0), 1'b0, -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
